// File: rtl/cache_arbiter_if.sv
// Bundle of the L1I, L1D and L2 ports around the cache arbiter.
//
// Handshake: each L1 holds its request (read/write), address and write data
// stable until it sees its one-cycle resp pulse. The arbiter holds its L2
// request stable until arbi_l2_resp pulses. The resp pulse is the only
// qualifier for the rdata buses, which otherwise carry arbi_l2_rdata.
interface cache_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              l1i_arbi_read;
  logic [ADDR_W-1:0] l1i_arbi_address;
  logic [LINE_W-1:0] l1i_arbi_rdata;
  logic              l1i_arbi_resp;

  logic              l1d_arbi_read;
  logic              l1d_arbi_write;
  logic [ADDR_W-1:0] l1d_arbi_address;
  logic [LINE_W-1:0] l1d_arbi_wdata;
  logic [LINE_W-1:0] l1d_arbi_rdata;
  logic              l1d_arbi_resp;

  logic              arbi_l2_read;
  logic              arbi_l2_write;
  logic [ADDR_W-1:0] arbi_l2_address;
  logic [LINE_W-1:0] arbi_l2_wdata;
  logic [LINE_W-1:0] arbi_l2_rdata;
  logic              arbi_l2_resp;

  // Arbiter side: serves the L1 clients and drives the L2 request.
  modport slave (
    input  l1i_arbi_read, l1i_arbi_address,
    output l1i_arbi_rdata, l1i_arbi_resp,
    input  l1d_arbi_read, l1d_arbi_write, l1d_arbi_address, l1d_arbi_wdata,
    output l1d_arbi_rdata, l1d_arbi_resp,
    output arbi_l2_read, arbi_l2_write, arbi_l2_address, arbi_l2_wdata,
    input  arbi_l2_rdata, arbi_l2_resp
  );

  // Environment side: the two L1 caches plus the L2.
  modport master (
    output l1i_arbi_read, l1i_arbi_address,
    input  l1i_arbi_rdata, l1i_arbi_resp,
    output l1d_arbi_read, l1d_arbi_write, l1d_arbi_address, l1d_arbi_wdata,
    input  l1d_arbi_rdata, l1d_arbi_resp,
    input  arbi_l2_read, arbi_l2_write, arbi_l2_address, arbi_l2_wdata,
    output arbi_l2_rdata, arbi_l2_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-client (L1I / L1D) arbiter in front of a single-ported L2.
// One transaction at a time: IDLE -> SERVE_x -> TURN -> IDLE. Ties in IDLE
// alternate using a one-bit last-grant flag and are counted (saturating).
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  cache_arbiter_if.slave bus,
  output logic [15:0]    conflict_count,
  output logic [1:0]     state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    TURN    = 2'd3
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] conflict_count_q, conflict_count_d;

  logic              i_req;
  logic              d_req;
  logic              l2_read_c;
  logic              l2_write_c;
  logic [ADDR_W-1:0] l2_addr_c;
  logic [LINE_W-1:0] l2_wdata_c;
  logic              i_resp_c;
  logic              d_resp_c;

  assign i_req = bus.l1i_arbi_read;
  assign d_req = bus.l1d_arbi_read | bus.l1d_arbi_write;

  // State register; reset makes the first tie go to L1I.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      last_grant_q     <= GRANT_D;
      conflict_count_q <= 16'h0000;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      conflict_count_q <= conflict_count_d;
    end
  end

  // Next-state: arbitrate in IDLE, wait for L2 resp in SERVE, one TURN bubble.
  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    conflict_count_d = conflict_count_q;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          if (conflict_count_q != 16'hFFFF) begin
            conflict_count_d = conflict_count_q + 16'd1;
          end
          if (last_grant_q == GRANT_D) begin
            state_d      = SERVE_I;
            last_grant_d = GRANT_I;
          end else begin
            state_d      = SERVE_D;
            last_grant_d = GRANT_D;
          end
        end else if (i_req) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
        end else if (d_req) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
        end
      end
      SERVE_I, SERVE_D: begin
        // Owner dropping its request does not abort; only L2 resp ends it.
        if (bus.arbi_l2_resp) begin
          state_d = TURN;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: L2 request and resp forwarding are pure functions of state and owner inputs.
  always_comb begin
    l2_read_c  = 1'b0;
    l2_write_c = 1'b0;
    l2_addr_c  = '0;
    l2_wdata_c = '0;
    i_resp_c   = 1'b0;
    d_resp_c   = 1'b0;
    case (state_q)
      SERVE_I: begin
        l2_read_c = 1'b1;
        l2_addr_c = bus.l1i_arbi_address;
        i_resp_c  = bus.arbi_l2_resp;
      end
      SERVE_D: begin
        l2_read_c  = bus.l1d_arbi_read;
        l2_write_c = bus.l1d_arbi_write;
        l2_addr_c  = bus.l1d_arbi_address;
        l2_wdata_c = bus.l1d_arbi_wdata;
        d_resp_c   = bus.arbi_l2_resp;
      end
      default: ;
    endcase
  end

  assign bus.arbi_l2_read    = l2_read_c;
  assign bus.arbi_l2_write   = l2_write_c;
  assign bus.arbi_l2_address = l2_addr_c;
  assign bus.arbi_l2_wdata   = l2_wdata_c;
  assign bus.l1i_arbi_resp   = i_resp_c;
  assign bus.l1d_arbi_resp   = d_resp_c;
  // Read data is broadcast; resp alone marks it valid for its owner.
  assign bus.l1i_arbi_rdata  = bus.arbi_l2_rdata;
  assign bus.l1d_arbi_rdata  = bus.arbi_l2_rdata;

  assign conflict_count = conflict_count_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single-client reads and writes, tie
// alternation, stray L2 resp, async reset mid-transaction, counter saturation.
module tb_cache_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SERVE_I = 2'd1;
  localparam logic [1:0] S_SERVE_D = 2'd2;
  localparam logic [1:0] S_TURN    = 2'd3;

  logic        clk;
  logic        rst_n;
  logic [15:0] conflict_count;
  logic [1:0]  state_dbg;

  int n_cmp;
  int n_mis;

  logic [LINE_W-1:0] line_a;
  logic [LINE_W-1:0] line_ones;

  cache_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .conflict_count (conflict_count),
    .state_dbg      (state_dbg)
  );

  // Clock: 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_line(input string tag, input logic [LINE_W-1:0] obs,
                            input logic [LINE_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_l2rd"}, 64'(bus.arbi_l2_read), 64'd0);
    check({tag, "_l2wr"}, 64'(bus.arbi_l2_write), 64'd0);
    check({tag, "_iresp"}, 64'(bus.l1i_arbi_resp), 64'd0);
    check({tag, "_dresp"}, 64'(bus.l1d_arbi_resp), 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    line_a    = {8{32'hA5C3_0F1E}};
    line_ones = '1;
    rst_n = 1'b0;
    bus.l1i_arbi_read    = 1'b0;
    bus.l1i_arbi_address = '0;
    bus.l1d_arbi_read    = 1'b0;
    bus.l1d_arbi_write   = 1'b0;
    bus.l1d_arbi_address = '0;
    bus.l1d_arbi_wdata   = '0;
    bus.arbi_l2_rdata    = '0;
    bus.arbi_l2_resp     = 1'b0;

    // Reset state
    #12;
    check("rst_state", 64'(state_dbg), 64'(S_IDLE));
    check("rst_cnt", 64'(conflict_count), 64'd0);
    check_quiet("rst");
    tick();
    rst_n = 1'b1;

    // L1I read, addr 0x1000, L2 resp in the third serve cycle
    tick();
    bus.l1i_arbi_read    = 1'b1;
    bus.l1i_arbi_address = 32'h0000_1000;
    #1;
    check("i_idle_state", 64'(state_dbg), 64'(S_IDLE));
    check("i_idle_l2rd", 64'(bus.arbi_l2_read), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) begin
        bus.arbi_l2_resp  = 1'b1;
        bus.arbi_l2_rdata = line_a;
      end
      #1;
      check("i_serve_state", 64'(state_dbg), 64'(S_SERVE_I));
      check("i_serve_l2rd", 64'(bus.arbi_l2_read), 64'd1);
      check("i_serve_l2wr", 64'(bus.arbi_l2_write), 64'd0);
      check("i_serve_addr", 64'(bus.arbi_l2_address), 64'h1000);
      check("i_serve_iresp", 64'(bus.l1i_arbi_resp), (k == 2) ? 64'd1 : 64'd0);
      check("i_serve_dresp", 64'(bus.l1d_arbi_resp), 64'd0);
    end
    check_line("i_rdata", bus.l1i_arbi_rdata, line_a);
    check_line("d_rdata_bcast", bus.l1d_arbi_rdata, line_a);
    tick();
    bus.l1i_arbi_read = 1'b0;
    bus.arbi_l2_resp  = 1'b0;
    #1;
    check("i_turn_state", 64'(state_dbg), 64'(S_TURN));
    check_quiet("i_turn");
    tick();
    #1;
    check("i_back_idle", 64'(state_dbg), 64'(S_IDLE));
    check("i_cnt", 64'(conflict_count), 64'd0);

    // L1D write, addr 0x2000, wdata all ones, immediate L2 resp
    bus.l1d_arbi_write   = 1'b1;
    bus.l1d_arbi_address = 32'h0000_2000;
    bus.l1d_arbi_wdata   = line_ones;
    #1;
    check("d_idle_l2wr", 64'(bus.arbi_l2_write), 64'd0);
    tick();
    bus.arbi_l2_resp = 1'b1;
    #1;
    check("d_serve_state", 64'(state_dbg), 64'(S_SERVE_D));
    check("d_serve_l2wr", 64'(bus.arbi_l2_write), 64'd1);
    check("d_serve_l2rd", 64'(bus.arbi_l2_read), 64'd0);
    check("d_serve_addr", 64'(bus.arbi_l2_address), 64'h2000);
    check_line("d_serve_wdata", bus.arbi_l2_wdata, line_ones);
    check("d_serve_dresp", 64'(bus.l1d_arbi_resp), 64'd1);
    check("d_serve_iresp", 64'(bus.l1i_arbi_resp), 64'd0);
    tick();
    bus.l1d_arbi_write = 1'b0;
    bus.arbi_l2_resp   = 1'b0;
    #1;
    check("d_turn_state", 64'(state_dbg), 64'(S_TURN));
    check_quiet("d_turn");
    tick();
    #1;
    check("d_back_idle", 64'(state_dbg), 64'(S_IDLE));

    // Ties from reset: L1I first, then L1D wins the next tie
    rst_n = 1'b0;
    #1;
    check("tie_rst_state", 64'(state_dbg), 64'(S_IDLE));
    tick();
    rst_n = 1'b1;
    bus.l1i_arbi_read    = 1'b1;
    bus.l1i_arbi_address = 32'h0000_3000;
    bus.l1d_arbi_read    = 1'b1;
    bus.l1d_arbi_address = 32'h0000_4000;
    #1;
    check("tie1_idle_cnt", 64'(conflict_count), 64'd0);
    tick();
    #1;
    check("tie1_state", 64'(state_dbg), 64'(S_SERVE_I));
    check("tie1_cnt", 64'(conflict_count), 64'd1);
    check("tie1_addr", 64'(bus.arbi_l2_address), 64'h3000);
    bus.arbi_l2_resp = 1'b1;
    #1;
    check("tie1_iresp", 64'(bus.l1i_arbi_resp), 64'd1);
    check("tie1_dresp", 64'(bus.l1d_arbi_resp), 64'd0);
    tick();
    bus.l1i_arbi_read = 1'b0;
    bus.arbi_l2_resp  = 1'b0;
    #1;
    check("tie1_turn", 64'(state_dbg), 64'(S_TURN));
    tick();
    bus.l1i_arbi_read    = 1'b1;
    bus.l1i_arbi_address = 32'h0000_5000;
    #1;
    check("tie2_idle", 64'(state_dbg), 64'(S_IDLE));
    tick();
    #1;
    check("tie2_state", 64'(state_dbg), 64'(S_SERVE_D));
    check("tie2_cnt", 64'(conflict_count), 64'd2);
    check("tie2_addr", 64'(bus.arbi_l2_address), 64'h4000);
    check("tie2_l2rd", 64'(bus.arbi_l2_read), 64'd1);
    bus.arbi_l2_resp = 1'b1;
    #1;
    check("tie2_dresp", 64'(bus.l1d_arbi_resp), 64'd1);
    check("tie2_iresp", 64'(bus.l1i_arbi_resp), 64'd0);
    tick();
    bus.l1d_arbi_read = 1'b0;
    bus.arbi_l2_resp  = 1'b0;
    #1;
    check("tie2_turn", 64'(state_dbg), 64'(S_TURN));
    tick();
    #1;
    check("tie3_idle", 64'(state_dbg), 64'(S_IDLE));
    tick();
    #1;
    check("tie3_state", 64'(state_dbg), 64'(S_SERVE_I));
    check("tie3_cnt", 64'(conflict_count), 64'd2);
    check("tie3_addr", 64'(bus.arbi_l2_address), 64'h5000);
    bus.arbi_l2_resp = 1'b1;
    tick();
    bus.l1i_arbi_read = 1'b0;
    bus.arbi_l2_resp  = 1'b0;
    tick();
    #1;
    check("tie3_idle_end", 64'(state_dbg), 64'(S_IDLE));

    // Stray L2 resp in IDLE is ignored
    bus.arbi_l2_resp = 1'b1;
    #1;
    check_quiet("stray_now");
    tick();
    #1;
    check("stray_state", 64'(state_dbg), 64'(S_IDLE));
    check_quiet("stray_next");
    bus.arbi_l2_resp = 1'b0;

    // Owner dropping its request mid-serve does not abort
    bus.l1i_arbi_read    = 1'b1;
    bus.l1i_arbi_address = 32'h0000_6000;
    tick();
    bus.l1i_arbi_read = 1'b0;
    #1;
    check("drop_state", 64'(state_dbg), 64'(S_SERVE_I));
    tick();
    #1;
    check("drop_hold_state", 64'(state_dbg), 64'(S_SERVE_I));
    check("drop_hold_l2rd", 64'(bus.arbi_l2_read), 64'd1);
    bus.arbi_l2_resp = 1'b1;
    #1;
    check("drop_iresp", 64'(bus.l1i_arbi_resp), 64'd1);
    tick();
    bus.arbi_l2_resp = 1'b0;
    #1;
    check("drop_turn", 64'(state_dbg), 64'(S_TURN));
    tick();
    #1;

    // Async reset while SERVE_D waits for L2
    bus.l1d_arbi_read    = 1'b1;
    bus.l1d_arbi_address = 32'h0000_7000;
    tick();
    #1;
    check("arst_pre_state", 64'(state_dbg), 64'(S_SERVE_D));
    check("arst_pre_l2rd", 64'(bus.arbi_l2_read), 64'd1);
    rst_n = 1'b0;
    bus.arbi_l2_resp = 1'b1;
    #1;
    check("arst_state", 64'(state_dbg), 64'(S_IDLE));
    check_quiet("arst_now");
    tick();
    bus.l1d_arbi_read = 1'b0;
    #1;
    check_quiet("arst_held");
    rst_n = 1'b1;
    tick();
    #1;
    check("arst_rel_state", 64'(state_dbg), 64'(S_IDLE));
    check_quiet("arst_rel");
    bus.arbi_l2_resp = 1'b0;
    tick();
    #1;
    check("arst_rel2_state", 64'(state_dbg), 64'(S_IDLE));

    // Saturation: preload the counter near the top, then force more ties
    dut.conflict_count_q = 16'hFFFC;
    bus.l1i_arbi_read = 1'b1;
    bus.l1d_arbi_read = 1'b1;
    bus.arbi_l2_resp  = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      #1;
      check("sat_cnt", 64'(conflict_count), (t < 3) ? 64'(16'hFFFD + 16'(t)) : 64'hFFFF);
      tick();
      tick();
    end
    bus.l1i_arbi_read = 1'b0;
    bus.l1d_arbi_read = 1'b0;
    bus.arbi_l2_resp  = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL take parameter ADDR_W, default 32, meaning the byte address width.
REQ-002 SHALL take parameter LINE_W, default 256, meaning the cache line width in bits.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; reset assertion SHALL take effect immediately, independent of clk.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous reset, active low.
REQ-006 l1i_arbi_read  in  1  L1I line-fill request; held until l1i_arbi_resp.
REQ-007 l1i_arbi_address  in  ADDR_W  L1I line address.
REQ-008 l1i_arbi_rdata  out  LINE_W  fill data to L1I.
REQ-009 l1i_arbi_resp  out  1  one-cycle L1I completion pulse.
REQ-010 l1d_arbi_read  in  1  L1D line-fill request; held until l1d_arbi_resp.
REQ-011 l1d_arbi_write  in  1  L1D writeback request; held until l1d_arbi_resp.
REQ-012 l1d_arbi_address  in  ADDR_W  L1D line address.
REQ-013 l1d_arbi_wdata  in  LINE_W  L1D writeback data.
REQ-014 l1d_arbi_rdata  out  LINE_W  fill data to L1D.
REQ-015 l1d_arbi_resp  out  1  one-cycle L1D completion pulse.
REQ-016 arbi_l2_read  out  1  read request to L2.
REQ-017 arbi_l2_write  out  1  write request to L2.
REQ-018 arbi_l2_address  out  ADDR_W  address to L2.
REQ-019 arbi_l2_wdata  out  LINE_W  write data to L2.
REQ-020 arbi_l2_rdata  in  LINE_W  L2 read data, valid with arbi_l2_resp.
REQ-021 arbi_l2_resp  in  1  L2 completion pulse.
REQ-022 conflict_count  out  16  count of cycles where both L1s requested in IDLE.

Function
REQ-023 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, TURN.
REQ-024 IDLE: only L1I requesting -> SERVE_I; only L1D (read or write) requesting -> SERVE_D; none -> stay IDLE.
REQ-025 IDLE with both requesting -> grant the side not granted last (1-bit last_grant flag, updated on each grant); conflict_count SHALL increment by 1, saturating at 16'hFFFF.
REQ-026 SHALL issue no L2 request and no resp in IDLE or TURN.
REQ-027 SERVE_I: arbi_l2_read=1, arbi_l2_write=0, arbi_l2_address=l1i_arbi_address.
REQ-028 SERVE_D: arbi_l2_read=l1d_arbi_read, arbi_l2_write=l1d_arbi_write, arbi_l2_address=l1d_arbi_address, arbi_l2_wdata=l1d_arbi_wdata.
REQ-029 Request outputs SHALL be combinational from state plus owner inputs; owner inputs SHALL be held stable by requester until resp.
REQ-030 In SERVE_x, arbi_l2_resp SHALL be forwarded combinationally, same cycle, to the owner's resp only; non-owner resp SHALL stay 0.
REQ-031 l1i_arbi_rdata and l1d_arbi_rdata SHALL both equal arbi_l2_rdata at all times; only resp qualifies them.
REQ-032 On arbi_l2_resp in SERVE_x -> TURN next cycle; otherwise stay in SERVE_x, no timeout.
REQ-033 TURN SHALL last exactly one cycle, then -> IDLE, so the requester drops its request before re-arbitration.
REQ-034 Minimum transaction latency: request seen in IDLE at cycle N, L2 request at N+1, owner resp same cycle as arbi_l2_resp.
REQ-035 arbi_l2_resp outside SERVE_x SHALL be ignored, with no state change and no resp forwarded.
REQ-036 L1D read and write both asserted SHALL be treated as one L1D request with both forwarded; legal L1D never does this.
REQ-037 Owner dropping its request mid-SERVE SHALL NOT abort the transaction; FSM waits for arbi_l2_resp.

Reset
REQ-038 rst_n low SHALL force state=IDLE, last_grant=D (first tie goes to L1I), conflict_count=0, all request and resp outputs 0.
REQ-039 Reset mid-transaction SHALL abandon it, with no resp generated during or after reset; the first edge after release SHALL evaluate IDLE.

Verification
REQ-040 L1I read only, addr 0x0000_1000, L2 resp after 3 cycles -> arbi_l2_read=1 with addr 0x1000 for 3 cycles, l1i_arbi_resp pulse with rdata, l1d_arbi_resp=0.
REQ-041 L1D write, addr 0x0000_2000, wdata all-ones -> arbi_l2_write=1, wdata all-ones, then l1d_arbi_resp one cycle, then TURN, then IDLE.
REQ-042 Both request from reset -> L1I served first, conflict_count=1; L1D served after TURN+IDLE; next simultaneous tie goes to L1D and conflict_count=2.
REQ-043 Stray arbi_l2_resp in IDLE -> no resp out, state unchanged.
REQ-044 rst_n low during SERVE_D awaiting resp -> outputs 0 immediately; after release with no requests, stays IDLE with no resp.
REQ-045 Force 65536 tie events -> conflict_count holds 16'hFFFF.
